// File: rtl/tea_iter_encryptor_if.sv
// Plaintext/ciphertext handshake bundle for the iterative TEA encryptor.
// The master drives plaintext and key and consumes the ciphertext; the slave is the encryptor.
interface tea_iter_encryptor_if;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  inBlock64;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  outBlock64;

  modport master (
    output in_valid, inBlock64, key, out_ready,
    input  in_ready, out_valid, outBlock64
  );

  modport slave (
    input  in_valid, inBlock64, key, out_ready,
    output in_ready, out_valid, outBlock64
  );
endinterface

// File: rtl/tea_iter_encryptor.sv
// Iterative TEA encryptor: one full cycle (both half-rounds) per clock, ROUNDS clocks per block.
// Optional CBC chaining is built when TEA_CBC_EN is defined; the default build is plain ECB.
//
// state | meaning
// IDLE  | in_ready high, waiting for a plaintext block
// RUN   | one TEA cycle per enabled clock, cnt counts completed cycles
// DONE  | out_valid high, ciphertext held until out_ready
module tea_iter_encryptor #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
`ifdef TEA_CBC_EN
  input  logic [63:0]                iv,
  input  logic                       iv_load,
`endif
  tea_iter_encryptor_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t        state_q;
  logic [5:0]    cnt_q;
  logic [31:0]   sum_q;
  logic [31:0]   v0_q;
  logic [31:0]   v1_q;
  logic [127:0]  key_q;
  logic [63:0]   out_q;
  logic          in_ready_q;
  logic          out_valid_q;

  logic [31:0]   k0, k1, k2, k3;
  logic [31:0]   sum_d;
  logic [31:0]   v0_d;
  logic [31:0]   v1_d;
  logic [63:0]   pt_in;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  // Second half-round deliberately consumes the freshly updated v0.
  assign sum_d = sum_q + DELTA;
  assign v0_d  = v0_q + (((v1_q << 4) + k0) ^ (v1_q + sum_d) ^ ((v1_q >> 5) + k1));
  assign v1_d  = v1_q + (((v0_d << 4) + k2) ^ (v0_d + sum_d) ^ ((v0_d >> 5) + k3));

`ifdef TEA_CBC_EN
  logic [63:0] chain_q;
  // A same-cycle iv_load takes precedence as the XOR operand for this block.
  assign pt_in = bus.inBlock64 ^ (iv_load ? iv : chain_q);
`else
  assign pt_in = bus.inBlock64;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      key_q       <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef TEA_CBC_EN
      chain_q     <= '0;
`endif
    end else if (ena) begin
      case (state_q)
        IDLE: begin
`ifdef TEA_CBC_EN
          if (iv_load) chain_q <= iv;
`endif
          if (bus.in_valid) begin
            v0_q       <= pt_in[63:32];
            v1_q       <= pt_in[31:0];
            key_q      <= bus.key;
            sum_q      <= '0;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          sum_q <= sum_d;
          v0_q  <= v0_d;
          v1_q  <= v1_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST) begin
            out_q       <= {v0_d, v1_d};
`ifdef TEA_CBC_EN
            chain_q     <= {v0_d, v1_d};
`endif
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.outBlock64 = out_q;

endmodule

// File: tb/tb_tea_iter_encryptor.sv
// Self-checking bench for tea_iter_encryptor: vector table, corner-case sequences and a random soak
// against a plain-arithmetic TEA encrypt/decrypt model. Builds with or without TEA_CBC_EN.
module tb_tea_iter_encryptor;
  localparam int unsigned ROUNDS = 32;
  localparam logic [31:0] DELTA  = 32'h9E3779B9;
  localparam logic [63:0] ZERO_CT = 64'h41EA3A0A94BAA940;

  logic clk = 1'b0;
  logic rst;
  logic ena;
`ifdef TEA_CBC_EN
  logic [63:0] iv;
  logic        iv_load;
`endif

  tea_iter_encryptor_if bus ();

  tea_iter_encryptor #(.ROUNDS(ROUNDS), .DELTA(DELTA)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
`ifdef TEA_CBC_EN
    .iv      (iv),
    .iv_load (iv_load),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] chain_m;

  typedef struct {
    logic [127:0] k;
    logic [63:0]  p;
    logic [63:0]  e;
  } vec_t;

  vec_t vt[6];

  function automatic logic [63:0] tea_enc(input logic [63:0] p, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = p[63:32];
    z = p[31:0];
    s = 32'd0;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      s = s + DELTA;
      y = y + (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      z = z + (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
    end
    return {y, z};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] c, input logic [127:0] k);
    logic [31:0] y, z, s;
    y = c[63:32];
    z = c[31:0];
    s = DELTA * ROUNDS;
    for (int i = 0; i < int'(ROUNDS); i++) begin
      z = z - (((y << 4) + k[63:32]) ^ (y + s) ^ ((y >> 5) + k[31:0]));
      y = y - (((z << 4) + k[127:96]) ^ (z + s) ^ ((z >> 5) + k[95:64]));
      s = s - DELTA;
    end
    return {y, z};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called right after a falling edge with the DUT idle; returns right after a falling edge.
  task automatic do_block(input logic [127:0] k, input logic [63:0] p, input logic [63:0] exp,
                          input bit load_iv, input int gap_at, input int gap_len,
                          input int out_wait, output logic [63:0] ct);
    int lat;
    bus.in_valid  = 1'b1;
    bus.key       = k;
    bus.inBlock64 = p;
`ifdef TEA_CBC_EN
    iv      = 64'd0;
    iv_load = load_iv;
`endif
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.key      = ~k;
`ifdef TEA_CBC_EN
    iv_load = 1'b0;
`endif
    chk("accept", {127'd0, bus.in_ready}, 128'd0);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      ena = !(lat >= gap_at && lat < gap_at + gap_len);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    chk("latency", 128'(lat), 128'(ROUNDS + gap_len));
    ct = bus.outBlock64;
    chk("cipher", {64'd0, ct}, {64'd0, exp});
    for (int i = 0; i < out_wait; i++) begin
      bus.in_valid  = 1'b1;
      bus.inBlock64 = {$urandom, $urandom};
      @(negedge clk);
      chk("hold", {62'd0, bus.out_valid, bus.in_ready, bus.outBlock64}, {62'd0, 2'b10, exp});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release", {126'd0, bus.in_ready, bus.out_valid}, {126'd0, 2'b10});
`ifdef TEA_CBC_EN
    chain_m = exp;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]  ct, prev, p;
    logic [127:0] k;

    rst           = 1'b1;
    ena           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inBlock64 = '0;
    bus.key       = '0;
    bus.out_ready = 1'b0;
`ifdef TEA_CBC_EN
    iv      = '0;
    iv_load = 1'b0;
`endif
    chain_m = '0;

    vt[0] = '{128'd0, 64'd0, ZERO_CT};
    vt[1] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 64'h01234567_89ABCDEF, 64'd0};
    vt[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'd0};
    vt[3] = '{128'h80000000_00000001_7FFFFFFF_FFFFFFFE, 64'h00000000_00000001, 64'd0};
    vt[4] = '{128'd0, 64'h80000000_00000000, 64'd0};
    vt[5] = '{128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 64'd0, 64'd0};
    for (int i = 1; i < 6; i++) vt[i].e = tea_enc(vt[i].p, vt[i].k);

    #12;
    chk("reset", {62'd0, bus.in_ready, bus.out_valid, bus.outBlock64}, {62'd0, 2'b10, 64'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) do_block(vt[i].k, vt[i].p, vt[i].e, 1'b1, 999, 0, i % 3, ct);

    // ena dropped for five clocks mid-RUN
    do_block(128'd0, 64'd0, ZERO_CT, 1'b1, 10, 5, 0, ct);

    // ten clocks of back-pressure with in_valid pushed the whole time
    do_block(128'd0, 64'd0, ZERO_CT, 1'b1, 999, 0, 10, ct);

    // reset at cnt = 15 must clear outputs immediately
    bus.in_valid  = 1'b1;
    bus.key       = vt[1].k;
    bus.inBlock64 = vt[1].p;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_mid_run", {62'd0, bus.in_ready, bus.out_valid, bus.outBlock64}, {62'd0, 2'b10, 64'd0});
    @(negedge clk);
    rst = 1'b0;
    chain_m = '0;
    @(negedge clk);
    do_block(vt[2].k, vt[2].p, vt[2].e, 1'b1, 999, 0, 0, ct);

    for (int n = 0; n < 1000; n++) begin
      k    = {$urandom, $urandom, $urandom, $urandom};
      p    = {$urandom, $urandom};
      prev = chain_m;
      do_block(k, p, tea_enc(p ^ prev, k), 1'b0, 999, 0, int'($urandom_range(0, 3)), ct);
      chk("round_trip", {64'd0, tea_dec(ct, k) ^ prev}, {64'd0, p});
    end

`ifdef TEA_CBC_EN
    iv      = 64'd0;
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    chain_m = '0;
    do_block(128'd0, 64'd0, ZERO_CT, 1'b0, 999, 0, 0, ct);
    do_block(128'd0, 64'd0, tea_enc(ZERO_CT, 128'd0), 1'b0, 999, 0, 0, ct);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
